// File: rtl/hydro_axis_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hydro_axis_pkg
//  Description : Shared types and constants for the hydrophone AXI4-Stream
//                packer: sample width, channel count, frame struct and the
//                output FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package hydro_axis_pkg;

    localparam int SAMPLE_W = 16;
    localparam int NUM_CH   = 4;

    // ch3 is declared first so it lands in the most significant bits,
    // matching the ADC bus layout ch0=[15:0] ... ch3=[63:48].
    typedef struct packed {
        logic [SAMPLE_W-1:0] ch3;
        logic [SAMPLE_W-1:0] ch2;
        logic [SAMPLE_W-1:0] ch1;
        logic [SAMPLE_W-1:0] ch0;
    } frame_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } pack_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : frame_fifo
//  Description : Single-clock frame FIFO. Full/empty derive from a level
//                counter; pointers wrap modulo DEPTH. The read port is a
//                register loaded on pop, so it doubles as the packer's
//                output frame register.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_fifo
    import hydro_axis_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  frame_t                     push_data,
    input  logic                       pop,
    output frame_t                     pop_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    frame_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q,  level_d;
    frame_t             pop_data_q, pop_data_d;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LVL_W'(DEPTH));
    assign level    = level_q;
    assign pop_data = pop_data_q;

    // Next-state for pointers, level and the registered read port.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        pop_data_d = pop_data_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            pop_data_d = mem[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pop_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pop_data_q <= pop_data_d;
        end
    end

    // Storage array; when full, push and pop share an address and the read
    // above sees the old head before this write lands.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hydrophone_axis_packer.sv
`default_nettype none
// ============================================================================
//  Module      : hydrophone_axis_packer
//  Description : Captures 4x16-bit ADC frames into a frame FIFO and emits
//                each as a two-beat AXI4-Stream packet ({ch1,ch0} then
//                {ch3,ch2} with tlast). Rejected frames pulse frame_drop.
//                Optional macro PACKER_DROP_CNT_EN adds a 16-bit saturating
//                drop_count output.
//  Revision    : 1.0 - initial release
// ============================================================================
module hydrophone_axis_packer
    import hydro_axis_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          m_axis_aclk,
    input  logic                          m_axis_aresetn,
    input  logic                          smp_valid,
    input  logic [4*SAMPLE_W-1:0]         smp_data,
    output logic [2*SAMPLE_W-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          frame_drop,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef PACKER_DROP_CNT_EN
    ,
    output logic [15:0]                   drop_count
`endif
);

    pack_state_t state_q, state_d;
    logic        pop;
    logic        push;
    logic        fifo_empty;
    logic        fifo_full;
    frame_t      out_frame;
    logic        frame_drop_q, frame_drop_d;

    frame_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (m_axis_aclk),
        .rst_n     (m_axis_aresetn),
        .push      (push),
        .push_data (frame_t'(smp_data)),
        .pop       (pop),
        .pop_data  (out_frame),
        .level     (fifo_level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push         = smp_valid && (!fifo_full || pop);
    assign frame_drop_d = smp_valid && !push;

    // Output FSM next-state and pop request.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = BEAT0;
                end
            end
            BEAT0: begin
                if (m_axis_tready) begin
                    state_d = BEAT1;
                end
            end
            BEAT1: begin
                if (m_axis_tready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = BEAT0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered drop pulse.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q      <= IDLE;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    // Stream outputs decode registered state only, never tready.
    always_comb begin
        m_axis_tvalid = (state_q == BEAT0) || (state_q == BEAT1);
        m_axis_tlast  = (state_q == BEAT1);
        m_axis_tdata  = (state_q == BEAT1) ? {out_frame.ch3, out_frame.ch2}
                                           : {out_frame.ch1, out_frame.ch0};
    end

    assign frame_drop = frame_drop_q;

`ifdef PACKER_DROP_CNT_EN
    logic [15:0] drop_count_q, drop_count_d;

    // Saturating drop counter, stepping alongside the frame_drop pulse.
    always_comb begin
        drop_count_d = drop_count_q;
        if (frame_drop_d && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            drop_count_q <= 16'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule
`default_nettype wire
